// File: rtl/wb_pkg.sv
// Shared types for the write-back store unit.
//   - WB_DATA_W / WB_ADDR_W : default result and register-address widths
//   - wb_state_e            : store FSM states
//   - wb_entry_t            : one buffered {destination address, result} pair
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t pairs waiting to be written back.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset (empties the FIFO)
//   push_i, entry_i  : enqueue entry_i (ignored while full)
//   pop_i            : dequeue the head (ignored while empty)
//   head_o           : oldest entry, valid while !empty_o
//   count_o          : number of buffered entries (0..DEPTH)
//   full_o, empty_o  : decoded from the registered count
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int FCNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  wb_entry_t         entry_i,
  input  logic              pop_i,
  output wb_entry_t         head_o,
  output logic [FCNT_W-1:0] count_o,
  output logic              full_o,
  output logic              empty_o
);

  wb_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [FCNT_W-1:0] count_q;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o    = (count_q == FCNT_W'(DEPTH));
  assign empty_o   = (count_q == {FCNT_W{1'b0}});
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {FCNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + FCNT_W'(1);
        2'b01:   count_q <= count_q - FCNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_store_unit.sv
// Write-back store unit: buffers {addr, result} pairs from the ALU stage,
// writes each into the register bank, reads it back and flags mismatches.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   in_valid/in_ready/in_addr/in_data : producer handshake (push on valid&&ready)
//   mem_addr/mem_wdata/mem_we       : single bank port, also used for read-back
//   mem_rdata                       : combinational bank read data at mem_addr
//   busy                            : work pending (FIFO non-empty or FSM active)
//   wr_count                        : verified writes, wraps modulo 2^CNT_W
//   err/err_addr                    : sticky mismatch flag and first failing address
// Entry widths come from wb_pkg; DATA_W/ADDR_W must match the package values.
module wb_store_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int FCNT_W = $clog2(DEPTH) + 1;

  wb_state_e         state_q;
  wb_state_e         state_d;
  logic [CNT_W-1:0]  wr_count_q;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;

  wb_entry_t         entry_s;
  wb_entry_t         head_s;
  logic [FCNT_W-1:0] fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              mismatch_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Ready depends only on the registered count, so a same-cycle pop never
  // re-opens a full FIFO.
  assign in_ready = !fifo_full_s;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = (state_q == CHECK);

  assign entry_s.addr = in_addr;
  assign entry_s.data = in_data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .entry_i (entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // The head has just been written, so the bank must return its data now.
  assign mismatch_s = (state_q == CHECK) && (mem_rdata != head_s.data);

  // Next-state and bank-port drive for the write / read-back sequence.
  always_comb begin
    state_d     = state_q;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        mem_we_s    = 1'b1;
        mem_addr_s  = head_s.addr;
        mem_wdata_s = head_s.data;
        state_d     = CHECK;
      end
      CHECK: begin
        mem_addr_s  = head_s.addr;
        mem_wdata_s = head_s.data;
        // Work remains after this pop if another entry is queued or arriving.
        if ((fifo_count_s > FCNT_W'(1)) || push_s) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, completed-write counter and first-mismatch capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_count_q <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
      err_addr_q <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      if (pop_s) begin
        wr_count_q <= wr_count_q + CNT_W'(1);
      end
      if (mismatch_s && !err_q) begin
        err_q      <= 1'b1;
        err_addr_q <= head_s.addr;
      end
    end
  end

  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;
  assign busy      = (state_q != IDLE) || !fifo_empty_s;
  assign wr_count  = wr_count_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule
